mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction / data) to single physical memory arbiter.
//
// Data requests win contention, but an instruction request that has watched
// STARVE_LIMIT consecutive data grants gets the next slot. One transaction is
// in flight at a time; a serve state is held until pmem_resp, then the FSM
// always passes through IDLE before the next grant.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_mem_read/address              instruction line read request
//   i_mem_rdata/resp                instruction read data and completion
//   d_mem_read/write/address/wdata  data line read or writeback request
//   d_mem_rdata/resp                data read data and completion
//   pmem_read/write/address/wdata   physical memory request
//   pmem_rdata/resp                 physical memory read data and completion pulse
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_mem_read,
  input  logic [15:0]  i_mem_address,
  output logic [127:0] i_mem_rdata,
  output logic         i_mem_resp,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  logic [15:0]  d_mem_address,
  input  logic [127:0] d_mem_wdata,
  output logic [127:0] d_mem_rdata,
  output logic         d_mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  // Keep the counter at least one bit wide when STARVE_LIMIT is 0.
  localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            i_pend, d_pend;

  assign i_pend = i_mem_read;
  assign d_pend = d_mem_read | d_mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Next state; the starvation counter only moves when leaving IDLE.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (i_pend && (!d_pend || (starve_cnt_q == Limit))) begin
          state_d      = StServeI;
          starve_cnt_d = '0;
        end else if (d_pend) begin
          state_d = StServeD;
          if (i_pend) begin
            starve_cnt_d = (starve_cnt_q == Limit) ? starve_cnt_q : starve_cnt_q + 1'b1;
          end else begin
            starve_cnt_d = '0;
          end
        end
      end
      StServeI, StServeD: begin
        // Withdrawn requests do not end a transaction; only the completion does.
        if (pmem_resp) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Physical memory strobes follow the live inputs of the port being served.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state_q)
      StServeI: begin
        pmem_read    = 1'b1;
        pmem_address = i_mem_address;
      end
      StServeD: begin
        pmem_write   = d_mem_write;
        pmem_read    = d_mem_read & ~d_mem_write;
        pmem_address = d_mem_address;
        pmem_wdata   = d_mem_wdata;
      end
      default: ;
    endcase
  end

  assign i_mem_resp  = pmem_resp & (state_q == StServeI);
  assign d_mem_resp  = pmem_resp & (state_q == StServeD);
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (STARVE_LIMIT = 2).
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_mem_read;
  logic [15:0]  i_mem_address;
  logic [127:0] i_mem_rdata;
  logic         i_mem_resp;
  logic         d_mem_read;
  logic         d_mem_write;
  logic [15:0]  d_mem_address;
  logic [127:0] d_mem_wdata;
  logic [127:0] d_mem_rdata;
  logic         d_mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  localparam logic [127:0] PatA5 = {16{8'hA5}};
  localparam logic [127:0] PatRd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_mem_read    (i_mem_read),
    .i_mem_address (i_mem_address),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_resp    (i_mem_resp),
    .d_mem_read    (d_mem_read),
    .d_mem_write   (d_mem_write),
    .d_mem_address (d_mem_address),
    .d_mem_wdata   (d_mem_wdata),
    .d_mem_rdata   (d_mem_rdata),
    .d_mem_resp    (d_mem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_rd"}, pmem_read, 1'b0);
    chk1({tag, "_wr"}, pmem_write, 1'b0);
    chk16({tag, "_addr"}, pmem_address, 16'h0000);
  endtask

  // Contention grant order: 1 = instruction, 0 = data.
  logic exp_i [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n         = 1'b0;
    i_mem_read    = 1'b0;
    i_mem_address = 16'h0000;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_mem_address = 16'h0000;
    d_mem_wdata   = '0;
    pmem_rdata    = '0;
    pmem_resp     = 1'b0;

    // Reset state, with requests and a completion pulse present.
    #1;
    i_mem_read = 1'b1;
    d_mem_write = 1'b1;
    d_mem_wdata = PatA5;
    pmem_resp = 1'b1;
    #1;
    chk_idle("rst");
    chk128("rst_wdata", pmem_wdata, '0);
    chk1("rst_iresp", i_mem_resp, 1'b0);
    chk1("rst_dresp", d_mem_resp, 1'b0);
    step();
    chk_idle("rst_hold");
    i_mem_read = 1'b0;
    d_mem_write = 1'b0;
    d_mem_wdata = '0;
    pmem_resp = 1'b0;
    rst_n = 1'b1;
    step();

    // I-only read, completion 3 cycles after the strobe.
    i_mem_read = 1'b1;
    i_mem_address = 16'h1230;
    #1;
    chk1("i_pre_rd", pmem_read, 1'b0);
    step();
    chk1("i_rd", pmem_read, 1'b1);
    chk1("i_wr", pmem_write, 1'b0);
    chk16("i_addr", pmem_address, 16'h1230);
    step();
    step();
    step();
    chk1("i_rd_held", pmem_read, 1'b1);
    pmem_resp = 1'b1;
    pmem_rdata = PatRd;
    #1;
    chk1("i_iresp", i_mem_resp, 1'b1);
    chk1("i_dresp", d_mem_resp, 1'b0);
    chk128("i_rdata", i_mem_rdata, PatRd);
    chk128("d_rdata", d_mem_rdata, PatRd);
    step();
    pmem_resp = 1'b0;
    i_mem_read = 1'b0;
    #1;
    chk_idle("i_after");
    chk1("i_after_iresp", i_mem_resp, 1'b0);

    // D writeback.
    d_mem_write = 1'b1;
    d_mem_address = 16'h4440;
    d_mem_wdata = PatA5;
    step();
    chk1("dw_wr", pmem_write, 1'b1);
    chk1("dw_rd", pmem_read, 1'b0);
    chk16("dw_addr", pmem_address, 16'h4440);
    chk128("dw_wdata", pmem_wdata, PatA5);
    pmem_resp = 1'b1;
    #1;
    chk1("dw_dresp", d_mem_resp, 1'b1);
    chk1("dw_iresp", i_mem_resp, 1'b0);
    step();
    pmem_resp = 1'b0;
    d_mem_write = 1'b0;
    #1;
    chk_idle("dw_after");
    chk128("dw_after_wdata", pmem_wdata, '0);

    // Stray completion while idle.
    pmem_resp = 1'b1;
    #1;
    chk1("stray_iresp", i_mem_resp, 1'b0);
    chk1("stray_dresp", d_mem_resp, 1'b0);
    step();
    pmem_resp = 1'b0;
    #1;
    chk_idle("stray_after");

    // Simultaneous D read and write; then withdraw the write mid-transaction.
    d_mem_read = 1'b1;
    d_mem_write = 1'b1;
    d_mem_address = 16'h0100;
    d_mem_wdata = PatRd;
    step();
    chk1("drw_wr", pmem_write, 1'b1);
    chk1("drw_rd", pmem_read, 1'b0);
    d_mem_write = 1'b0;
    #1;
    chk1("drw_wd_rd", pmem_read, 1'b1);
    chk1("drw_wd_wr", pmem_write, 1'b0);
    step();
    d_mem_read = 1'b0;
    #1;
    chk1("drw_gone_rd", pmem_read, 1'b0);
    chk16("drw_gone_addr", pmem_address, 16'h0100);
    pmem_resp = 1'b1;
    #1;
    chk1("drw_dresp", d_mem_resp, 1'b1);
    step();
    pmem_resp = 1'b0;
    #1;
    chk_idle("drw_after");

    // Contention: both ports held, grants D, D, I, D, D, I.
    i_mem_read = 1'b1;
    i_mem_address = 16'h1000;
    d_mem_read = 1'b1;
    d_mem_address = 16'h2000;
    #1;
    for (int g = 0; g < 6; g++) begin
      chk1($sformatf("cont%0d_idle_rd", g), pmem_read, 1'b0);
      step();
      chk1($sformatf("cont%0d_rd", g), pmem_read, 1'b1);
      chk16($sformatf("cont%0d_addr", g), pmem_address, exp_i[g] ? 16'h1000 : 16'h2000);
      pmem_resp = 1'b1;
      #1;
      chk1($sformatf("cont%0d_iresp", g), i_mem_resp, exp_i[g]);
      chk1($sformatf("cont%0d_dresp", g), d_mem_resp, !exp_i[g]);
      step();
      pmem_resp = 1'b0;
      #1;
    end
    i_mem_read = 1'b0;
    d_mem_read = 1'b0;
    #1;
    chk_idle("cont_after");

    // Reset in the middle of a D writeback, then an I request goes first.
    d_mem_write = 1'b1;
    d_mem_address = 16'h5550;
    d_mem_wdata = PatA5;
    step();
    chk1("rm_wr", pmem_write, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rm_wr_rst", pmem_write, 1'b0);
    chk16("rm_addr_rst", pmem_address, 16'h0000);
    chk128("rm_wdata_rst", pmem_wdata, '0);
    d_mem_write = 1'b0;
    i_mem_read = 1'b1;
    i_mem_address = 16'h7770;
    step();
    chk1("rm_hold_rd", pmem_read, 1'b0);
    rst_n = 1'b1;
    #1;
    chk1("rm_rel_rd", pmem_read, 1'b0);
    step();
    chk1("rm_i_rd", pmem_read, 1'b1);
    chk16("rm_i_addr", pmem_address, 16'h7770);
    pmem_resp = 1'b1;
    #1;
    chk1("rm_iresp", i_mem_resp, 1'b1);
    step();
    pmem_resp = 1'b0;
    i_mem_read = 1'b0;
    #1;
    chk_idle("rm_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
